// File: rtl/ascon_absorb_engine_if.sv
// Handshake/bus bundle for the Ascon absorb engine.
// master: the block feeding state, length and data blocks.
// slave : the absorb engine itself.
interface ascon_absorb_engine_if #(
  parameter int LEN_W = 32
) ();
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] total_len;
  logic [319:0]     state_i;
  logic             blk_valid;
  logic             blk_ready;
  logic [127:0]     blk_data;
  logic [319:0]     state_o;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      perf_cycles;

  modport master (
    output start, mode, total_len, state_i, blk_valid, blk_data,
    input  blk_ready, state_o, busy, done, err, perf_cycles
  );

  modport slave (
    input  start, mode, total_len, state_i, blk_valid, blk_data,
    output blk_ready, state_o, busy, done, err, perf_cycles
  );
endinterface

// File: rtl/ascon_absorb_engine.sv
// Streaming Ascon absorb engine: loads a 320-bit state and a byte length,
// absorbs rate-sized blocks (16 B for AEAD128, 8 B otherwise) with internal
// padding, and runs an iterative permutation (UNROLL rounds per clock) after
// every block. A padding-only block is generated internally when the data is
// empty or an exact multiple of the rate.
// Optional feature macro: ASCON_ABSORB_PERF_EN enables the busy-cycle counter
// on perf_cycles; without it perf_cycles is tied to zero.
module ascon_absorb_engine #(
  parameter int UNROLL = 1,   // rounds per clock: 1, 2 or 4
  parameter int LEN_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ascon_absorb_engine_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PAD  = 3'd2;
  localparam logic [2:0] S_PERM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] M_AEAD = 2'b00;
  localparam logic [3:0] STEP   = 4'(UNROLL);

  // Rotate a 64-bit lane right by n (n is never 0 here).
  function automatic logic [63:0] f_rotr(input logic [63:0] v, input int unsigned n);
    f_rotr = (v >> n) | (v << (32'd64 - n));
  endfunction

  // Round constant for global round index i (0..11).
  function automatic logic [7:0] f_rc(input logic [3:0] i);
    f_rc = 8'hF0 - ({4'd0, i} * 8'h0F);
  endfunction

  // One Ascon round: constant add, bitsliced 5-bit S-box, linear diffusion.
  function automatic logic [319:0] f_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[63:0];
    x1 = s[127:64];
    x2 = s[191:128] ^ {56'd0, c};
    x3 = s[255:192];
    x4 = s[319:256];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ f_rotr(x0, 32'd19) ^ f_rotr(x0, 32'd28);
    x1 = x1 ^ f_rotr(x1, 32'd61) ^ f_rotr(x1, 32'd39);
    x2 = x2 ^ f_rotr(x2, 32'd1)  ^ f_rotr(x2, 32'd6);
    x3 = x3 ^ f_rotr(x3, 32'd10) ^ f_rotr(x3, 32'd17);
    x4 = x4 ^ f_rotr(x4, 32'd7)  ^ f_rotr(x4, 32'd41);
    f_round = {x4, x3, x2, x1, x0};
  endfunction

  logic [2:0]       r_fsm;
  logic [319:0]     r_state;
  logic [LEN_W-1:0] r_rem;
  logic [1:0]       r_mode;
  logic             r_final;
  logic [3:0]       r_rnd;      // global index of the next round to apply
  logic             r_busy;
  logic             r_blk_ready;
  logic             r_done;
  logic             r_err;

  logic [2:0]       w_fsm_nxt;
  logic [319:0]     w_state_nxt;
  logic [LEN_W-1:0] w_rem_nxt;
  logic [1:0]       w_mode_nxt;
  logic             w_final_nxt;
  logic [3:0]       w_rnd_nxt;

  logic [4:0]       w_rate;
  logic             w_full;
  logic [3:0]       w_nb;
  logic [127:0]     w_blk;
  logic [319:0]     w_perm;
  logic [3:0]       w_rnd_init;
  logic             w_last;

  assign w_rate     = (r_mode == M_AEAD) ? 5'd16 : 5'd8;
  assign w_rnd_init = (r_mode == M_AEAD) ? 4'd4 : 4'd0;   // p8 runs rounds 4..11
  assign w_full     = (r_rem >= LEN_W'(w_rate));
  assign w_nb       = r_rem[3:0];
  assign w_last     = ((r_rnd + STEP) == 4'd12);

  // Masked and padded rate block: keep valid bytes, append 0x01 after a partial block.
  always_comb begin
    w_blk = 128'd0;
    for (int b = 0; b < 16; b++) begin
      w_blk[8*b +: 8] =
        ((w_full ? (5'(b) < w_rate) : (4'(b) < w_nb)) ? bus.blk_data[8*b +: 8] : 8'h00) |
        ((!w_full && (4'(b) == w_nb)) ? 8'h01 : 8'h00);
    end
  end

  // UNROLL chained rounds starting at the current round index.
  always_comb begin
    w_perm = r_state;
    for (int k = 0; k < UNROLL; k++) begin
      w_perm = f_round(w_perm, f_rc(r_rnd + 4'(k)));
    end
  end

  // Next-state and datapath selection for the absorb FSM.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    w_final_nxt = r_final;
    w_rnd_nxt   = r_rnd;
    case (r_fsm)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = bus.state_i;
          w_rem_nxt   = bus.total_len;
          w_mode_nxt  = bus.mode;
          w_final_nxt = 1'b0;
          w_fsm_nxt   = (bus.total_len == '0) ? S_PAD : S_WAIT;
        end else begin
          w_fsm_nxt   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.blk_valid && r_blk_ready) begin
          w_state_nxt = r_state ^ {192'd0, w_blk};
          w_rem_nxt   = w_full ? (r_rem - LEN_W'(w_rate)) : '0;
          w_final_nxt = !w_full;
          w_rnd_nxt   = w_rnd_init;
          w_fsm_nxt   = S_PERM;
        end else begin
          w_fsm_nxt   = S_WAIT;
        end
      end
      S_PAD: begin
        w_state_nxt = r_state ^ {312'd0, 8'h01};
        w_final_nxt = 1'b1;
        w_rnd_nxt   = w_rnd_init;
        w_fsm_nxt   = S_PERM;
      end
      S_PERM: begin
        w_rnd_nxt = r_rnd + STEP;
        if (w_last && r_final) begin
          // domain-separation flip on x4 for AEAD when the absorb completes
          w_state_nxt = w_perm ^ ((r_mode == M_AEAD) ? {1'b1, 319'd0} : 320'd0);
          w_fsm_nxt   = S_DONE;
        end else if (w_last) begin
          w_state_nxt = w_perm;
          w_fsm_nxt   = (r_rem == '0) ? S_PAD : S_WAIT;
        end else begin
          w_state_nxt = w_perm;
          w_fsm_nxt   = S_PERM;
        end
      end
      S_DONE: begin
        w_fsm_nxt = S_IDLE;
      end
      default: begin
        w_fsm_nxt = S_IDLE;
      end
    endcase
  end

  // State registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= 320'd0;
      r_rem       <= '0;
      r_mode      <= 2'b00;
      r_final     <= 1'b0;
      r_rnd       <= 4'd0;
      r_busy      <= 1'b0;
      r_blk_ready <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_mode      <= w_mode_nxt;
      r_final     <= w_final_nxt;
      r_rnd       <= w_rnd_nxt;
      r_busy      <= (w_fsm_nxt != S_IDLE);
      r_blk_ready <= (w_fsm_nxt == S_WAIT);
      r_done      <= (w_fsm_nxt == S_DONE);
      r_err       <= bus.start && (r_fsm != S_IDLE);
    end
  end

  assign bus.state_o   = r_state;
  assign bus.busy      = r_busy;
  assign bus.blk_ready = r_blk_ready;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

`ifdef ASCON_ABSORB_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of busy cycles, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= 32'd0;
    end else if ((r_fsm == S_IDLE) && bus.start) begin
      r_perf <= 32'd0;
    end else if ((r_fsm != S_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end else begin
      r_perf <= r_perf;
    end
  end

  assign bus.perf_cycles = r_perf;
`else
  assign bus.perf_cycles = 32'd0;
`endif

endmodule
